// File: rtl/regfile_alu_pkg.sv
// Shared types for the register-file ALU controller.
// Holds width defaults, opcode and FSM state encodings.
package regfile_alu_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MOV = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_alu.sv
// Combinational ALU: (op, a, b) -> (y, c).
// Ports: op opcode, a/b operands, y result, c carry/borrow/shift-out.
import regfile_alu_pkg::*;

module regfile_alu #(
  parameter int DATA_W = RF_DATA_W
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              c
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic [DATA_W:0] shl;
  logic [DATA_W:0] shr;
  logic [2:0]      sh;

  assign sh   = b[2:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  // top bit of the wide difference is the borrow (a < b)
  assign diff = {1'b0, a} - {1'b0, b};
  // one guard bit catches the last bit shifted out;
  // a zero shift leaves the guard bit clear
  assign shl  = {1'b0, a} << sh;
  assign shr  = {a, 1'b0} >> sh;

  always_comb begin
    y = '0;
    c = 1'b0;
    unique case (op)
      OP_ADD: begin
        y = sum[DATA_W-1:0];
        c = sum[DATA_W];
      end
      OP_SUB: begin
        y = diff[DATA_W-1:0];
        c = diff[DATA_W];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y = shl[DATA_W-1:0];
        c = shl[DATA_W];
      end
      OP_SHR: begin
        y = shr[DATA_W:1];
        c = shr[0];
      end
      OP_MOV: y = a;
      default: begin
        y = '0;
        c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_alu_ctrl.sv
// Multi-cycle execute controller driving an 8x8 register file.
// Ports: cmd_* handshake in, ra/rd read port, wa/wd/we write port, done/result/flags.
import regfile_alu_pkg::*;

module regfile_alu_ctrl #(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              we,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c
);

  state_t            state;
  state_t            nxt;
  op_t               op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] y_q;
  logic              z_q;
  logic              c_q;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;

  regfile_alu #(.DATA_W(DATA_W)) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y),
    .c  (alu_c)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (cmd_valid) nxt = S_READ;
      S_READ: nxt = S_EXEC;
      S_EXEC: nxt = S_WB;
      S_WB:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // we follows state directly so reset drops it at once
  always_comb begin
    cmd_ready = (state == S_IDLE);
    we        = (state == S_WB);
    done      = (state == S_WB);
  end

  // ra1/ra2 double as the rs1/rs2 latch and hold after READ
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      op_q   <= OP_ADD;
      rd_q   <= '0;
      ra1    <= '0;
      ra2    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      y_q    <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q <= op_t'(cmd_op);
            ra1  <= cmd_rs1;
            ra2  <= cmd_rs2;
            rd_q <= cmd_rd;
          end
        end
        S_READ: begin
          a_q <= rd1;
          b_q <= rd2;
        end
        S_EXEC: begin
          y_q <= alu_y;
          z_q <= (alu_y == '0);
          c_q <= alu_c;
        end
        S_WB: begin
          result <= y_q;
          flag_z <= z_q;
          flag_c <= c_q;
        end
        default: ;
      endcase
    end
  end

  assign wa = rd_q;
  assign wd = y_q;

endmodule

// File: tb/tb_regfile_alu_ctrl.sv
// Self-checking bench for regfile_alu_ctrl with a behavioural 8x8 register file.
// Directed table, back-to-back, reset-abort and random sequences.
module tb_regfile_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [2:0] cmd_rs1 = '0;
  logic [2:0] cmd_rs2 = '0;
  logic [2:0] cmd_rd = '0;
  logic [2:0] ra1, ra2, wa;
  logic [7:0] rd1, rd2, wd, result;
  logic       we, done, flag_z, flag_c;

  logic [7:0] rf [8];
  logic       host = 1'b1;
  logic       h_we = 1'b0;
  logic [2:0] h_wa = '0;
  logic [7:0] h_wd = '0;

  int mrf [8];
  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  regfile_alu_ctrl dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .cmd_rd    (cmd_rd),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .wa        (wa),
    .wd        (wd),
    .we        (we),
    .done      (done),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c)
  );

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  always @(posedge clk) begin
    if (host) begin
      if (h_we) rf[h_wa] <= h_wd;
    end else if (we) begin
      rf[wa] <= wd;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int y, output int c);
    int s;
    s = b % 8;
    y = 0;
    c = 0;
    case (op)
      0: begin y = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1: begin y = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: begin
        y = (a * (1 << s)) % 256;
        c = (s == 0) ? 0 : (a >> (8 - s)) & 1;
      end
      6: begin
        y = a >> s;
        c = (s == 0) ? 0 : (a >> (s - 1)) & 1;
      end
      default: y = a;
    endcase
  endfunction

  task automatic model_exec(input int op, input int rs1, input int rs2,
                            input int rd, output int y, output int z,
                            output int c);
    ref_alu(op, mrf[rs1], mrf[rs2], y, c);
    z = (y == 0) ? 1 : 0;
    mrf[rd] = y;
  endtask

  task automatic preload(input int idx, input int val);
    @(negedge clk);
    host = 1'b1;
    h_we = 1'b1;
    h_wa = idx[2:0];
    h_wd = val[7:0];
    @(negedge clk);
    h_we = 1'b0;
    host = 1'b0;
    mrf[idx] = val;
  endtask

  task automatic run_cmd(input int op, input int rs1, input int rs2,
                         input int rd, output int res, output int z,
                         output int c, output int rfv);
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op  = op[2:0];
    cmd_rs1 = rs1[2:0];
    cmd_rs2 = rs2[2:0];
    cmd_rd  = rd[2:0];
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op  = 3'($urandom);
    cmd_rs1 = 3'($urandom);
    cmd_rs2 = 3'($urandom);
    cmd_rd  = 3'($urandom);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 10);
    chk("done_latency", k, 3);
    chk("we_in_wb", int'(we), 1);
    chk("wa_in_wb", int'(wa), rd);
    @(posedge clk);
    #1;
    res = int'(result);
    z   = int'(flag_z);
    c   = int'(flag_c);
    rfv = int'(rf[rd]);
    chk("ready_after_wb", int'(cmd_ready), 1);
  endtask

  typedef struct {
    int op;
    int rs1;
    int rs2;
    int rd;
    int y;
    int z;
    int c;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int res, z, c, rfv, my, mz, mc, ndone;
    int old;

    tbl[0]  = '{0, 3, 4, 5, 'h07, 0, 0};
    tbl[1]  = '{7, 5, 6, 1, 'h07, 0, 0};
    tbl[2]  = '{1, 2, 3, 0, 'hFF, 0, 1};
    tbl[3]  = '{1, 6, 6, 6, 'h00, 1, 0};
    tbl[4]  = '{5, 7, 1, 2, 'h02, 0, 1};
    tbl[5]  = '{6, 7, 1, 3, 'h40, 0, 1};
    tbl[6]  = '{2, 7, 4, 4, 'h00, 1, 0};
    tbl[7]  = '{3, 7, 1, 5, 'h81, 0, 0};
    tbl[8]  = '{5, 7, 6, 0, 'h81, 0, 0};
    tbl[9]  = '{0, 7, 7, 6, 'h02, 0, 1};
    tbl[10] = '{4, 2, 2, 2, 'h00, 1, 0};
    tbl[11] = '{6, 7, 3, 4, 'h81, 0, 0};

    repeat (2) @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_we", int'(we), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wa", int'(wa), 0);
    chk("rst_wd", int'(wd), 0);
    chk("rst_ra1", int'(ra1), 0);
    chk("rst_ra2", int'(ra2), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_z", int'(flag_z), 0);
    chk("rst_c", int'(flag_c), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) preload(i, i);

    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin
        preload(7, 'h81);
        preload(1, 1);
      end
      run_cmd(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, res, z, c, rfv);
      model_exec(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, my, mz, mc);
      chk($sformatf("tbl%0d_result", i), res, tbl[i].y);
      chk($sformatf("tbl%0d_z", i), z, tbl[i].z);
      chk($sformatf("tbl%0d_c", i), c, tbl[i].c);
      chk($sformatf("tbl%0d_rf", i), rfv, tbl[i].y);
    end

    // back-to-back: three commands with cmd_valid held high
    for (int i = 0; i < 8; i++) preload(i, i);
    ndone = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done) ndone++;
      if (cyc % 4 == 0) begin
        chk($sformatf("b2b_ready_c%0d", cyc), int'(cmd_ready), 1);
        case (cyc)
          0: begin cmd_op = 3'd4; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd0; end
          4: begin cmd_op = 3'd0; cmd_rs1 = 3'd4; cmd_rs2 = 3'd4; cmd_rd = 3'd4; end
          8: begin cmd_op = 3'd1; cmd_rs1 = 3'd4; cmd_rs2 = 3'd3; cmd_rd = 3'd7; end
          default: cmd_valid = 1'b0;
        endcase
      end else begin
        chk($sformatf("b2b_ready_c%0d", cyc), int'(cmd_ready), 0);
        if (cyc == 9) cmd_valid = 1'b0;
      end
    end
    model_exec(4, 1, 2, 0, my, mz, mc);
    model_exec(0, 4, 4, 4, my, mz, mc);
    model_exec(1, 4, 3, 7, my, mz, mc);
    chk("b2b_done_count", ndone, 3);
    chk("b2b_r0", int'(rf[0]), 3);
    chk("b2b_r4", int'(rf[4]), 8);
    chk("b2b_r7", int'(rf[7]), 5);
    chk("b2b_result", int'(result), 5);

    // reset during EXEC discards the command
    old = mrf[2];
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd0;
    cmd_rs1 = 3'd3;
    cmd_rs2 = 3'd4;
    cmd_rd = 3'd2;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_we", int'(we), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_ra1", int'(ra1), 0);
    chk("abort_wa", int'(wa), 0);
    chk("abort_wd", int'(wd), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_flags", int'({flag_z, flag_c}), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_we", int'(we), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rd_kept", int'(rf[2]), old);
    chk("abort_ready_rel", int'(cmd_ready), 1);
    run_cmd(0, 3, 4, 2, res, z, c, rfv);
    model_exec(0, 3, 4, 2, my, mz, mc);
    chk("post_rst_result", res, my);
    chk("post_rst_rf", rfv, my);

    // randomized commands against the reference model
    for (int i = 0; i < 8; i++) preload(i, int'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++) begin
      int op, rs1, rs2, rd;
      op  = int'($urandom_range(0, 7));
      rs1 = int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      rd  = int'($urandom_range(0, 7));
      run_cmd(op, rs1, rs2, rd, res, z, c, rfv);
      model_exec(op, rs1, rs2, rd, my, mz, mc);
      chk($sformatf("rnd%0d_op%0d_result", i, op), res, my);
      chk($sformatf("rnd%0d_op%0d_z", i, op), z, mz);
      chk($sformatf("rnd%0d_op%0d_c", i, op), c, mc);
      chk($sformatf("rnd%0d_op%0d_rf", i, op), rfv, my);
    end
    for (int i = 0; i < 8; i++)
      chk($sformatf("final_r%0d", i), int'(rf[i]), mrf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
